// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer port arbiter.
//   ADDR_W   : frame-buffer address width (640x480 needs 19 bits)
//   DATA_W   : pixel width (RGB332)
//   FB_DEPTH : number of legal pixel addresses; anything at or above is illegal
//   gnt_e    : grant encoding of the BRAM port owner for the current cycle
package fb_pkg;

    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 8;
    localparam int FB_DEPTH = 307200;

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } gnt_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous write FIFO holding {addr, data} pairs from the loader.
//   clk, rst_n      : clock, asynchronous active-low reset
//   push_i          : write push_addr_i/push_data_i (ignored while full)
//   pop_i           : drop the head entry (ignored while empty)
//   head_addr_o/_data_o : current head entry, valid while empty_o=0
//   level_o         : occupancy 0..DEPTH
//   full_o, empty_o : decoded from level_o
//   ready_o         : registered "level < DEPTH" computed from the next level,
//                     so it stays low during a cycle that pops from full and
//                     comes back one cycle after that pop
module fb_wr_fifo #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [ADDR_W-1:0]          push_addr_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_i,
    output logic [ADDR_W-1:0]          head_addr_o,
    output logic [DATA_W-1:0]          head_data_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       ready_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [PTR_W-1:0]         rd_ptr_q;
    logic [LVL_W-1:0]         level_q;
    logic [LVL_W-1:0]         level_d;
    logic                     ready_q;
    logic                     do_push;
    logic                     do_pop;

    assign full_o  = (level_q == DEPTH_L);
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointers are PTR_W bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            ready_q <= (level_d < DEPTH_L);
        end
    end

    // Storage needs no reset: entries are only read once level says valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= {push_addr_i, push_data_i};
    end

    assign head_addr_o = mem_q[rd_ptr_q][ADDR_W+DATA_W-1:DATA_W];
    assign head_data_o = mem_q[rd_ptr_q][DATA_W-1:0];
    assign level_o     = level_q;
    assign ready_o     = ready_q;

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares the single-port frame-buffer BRAM between the display read path and
// a FIFO-buffered write path.
//   clk, rst_n        : clock, asynchronous active-low reset
//   vblank_i          : vertical blanking, gates writes when WR_VBLANK_ONLY=1
//   rd_req_i/rd_addr_i: display pixel fetch, one-cycle pulse per pixel
//   rd_data_o/rd_valid_o : pixel returned two cycles after the request
//   wr_valid_i/wr_ready_o/wr_addr_i/wr_data_i : loader write handshake
//   mem_*_o, mem_rdata_i : BRAM port (read data has one cycle of latency)
//   fifo_level_o      : write FIFO occupancy
//   addr_err_o        : sticky out-of-range access flag, cleared by reset
//   gnt_state_o       : current grant state (debug visibility)
//
// Handshake: a write is accepted on a clock edge where wr_valid_i and
// wr_ready_o are both high; wr_addr_i/wr_data_i must be stable with
// wr_valid_i. Reads have no back-pressure: every rd_req_i pulse yields
// exactly one rd_valid_o pulse two cycles later.
module fb_port_arbiter #(
    parameter int ADDR_W         = fb_pkg::ADDR_W,
    parameter int DATA_W         = fb_pkg::DATA_W,
    parameter int FB_DEPTH       = fb_pkg::FB_DEPTH,
    parameter int FIFO_DEPTH     = 4,
    parameter int WR_VBLANK_ONLY = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        vblank_i,
    input  logic                        rd_req_i,
    input  logic [ADDR_W-1:0]           rd_addr_i,
    output logic [DATA_W-1:0]           rd_data_o,
    output logic                        rd_valid_o,
    input  logic                        wr_valid_i,
    output logic                        wr_ready_o,
    input  logic [ADDR_W-1:0]           wr_addr_i,
    input  logic [DATA_W-1:0]           wr_data_i,
    output logic                        mem_en_o,
    output logic                        mem_we_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [DATA_W-1:0]           mem_wdata_o,
    input  logic [DATA_W-1:0]           mem_rdata_i,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        addr_err_o,
    output logic [1:0]                  gnt_state_o
);

    import fb_pkg::*;

    function automatic logic in_fb(input logic [ADDR_W-1:0] a);
        return (64'(a) < 64'(FB_DEPTH));
    endfunction

    // Write FIFO
    logic              fifo_push;
    logic              fifo_pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              fifo_full;
    logic              fifo_empty;

    assign fifo_push = wr_valid_i && wr_ready_o && !fifo_full;

    fb_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_addr_i (wr_addr_i),
        .push_data_i (wr_data_i),
        .pop_i       (fifo_pop),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .level_o     (fifo_level_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .ready_o     (wr_ready_o)
    );

    // Grant FSM and registered BRAM drive
    gnt_e              state_q, state_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              addr_err_q, addr_err_d;
    logic              wr_allowed;

    // Read pipeline: stage 1 = BRAM access cycle, stage 2 = data return.
    // The out-of-range flag travels with the request so its slot returns 0.
    logic rd_v1_q, rd_v2_q;
    logic rd_oor_d, rd_oor1_q, rd_oor2_q;

    assign wr_allowed = (WR_VBLANK_ONLY == 0) || vblank_i;

    always_comb begin
        state_d     = GNT_IDLE;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        addr_err_d  = addr_err_q;
        fifo_pop    = 1'b0;
        rd_oor_d    = 1'b0;
        if (rd_req_i) begin
            // Reads always win the port, so a pending write can never delay one.
            state_d = GNT_RD;
            if (in_fb(rd_addr_i)) begin
                mem_en_d   = 1'b1;
                mem_addr_d = rd_addr_i;
            end else begin
                rd_oor_d   = 1'b1;
                addr_err_d = 1'b1;
            end
        end else if (!fifo_empty && wr_allowed) begin
            state_d  = GNT_WR;
            fifo_pop = 1'b1;
            if (in_fb(head_addr)) begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = head_addr;
                mem_wdata_d = head_data;
            end else begin
                // Illegal entry is still consumed so it cannot block the FIFO.
                addr_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= GNT_IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            addr_err_q  <= 1'b0;
            rd_v1_q     <= 1'b0;
            rd_v2_q     <= 1'b0;
            rd_oor1_q   <= 1'b0;
            rd_oor2_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            addr_err_q  <= addr_err_d;
            rd_v1_q     <= rd_req_i;
            rd_v2_q     <= rd_v1_q;
            rd_oor1_q   <= rd_oor_d;
            rd_oor2_q   <= rd_oor1_q;
        end
    end

    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign addr_err_o  = addr_err_q;
    assign gnt_state_o = state_q;
    assign rd_valid_o  = rd_v2_q;
    // BRAM data arrives in the cycle after mem_en, which is the return slot.
    assign rd_data_o   = (rd_v2_q && !rd_oor2_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_fb_port_arbiter.sv
module tb_fb_port_arbiter;

    localparam int AW = fb_pkg::ADDR_W;
    localparam int DW = fb_pkg::DATA_W;
    localparam int FD = fb_pkg::FB_DEPTH;

    // Clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (writes allowed any time)
    logic          vblank, rd_req, rd_valid, wr_valid, wr_ready;
    logic [AW-1:0] rd_addr, wr_addr, mem_addr;
    logic [DW-1:0] rd_data, wr_data, mem_wdata, mem_rdata;
    logic          mem_en, mem_we, addr_err;
    logic [2:0]    fifo_level;
    logic [1:0]    gnt_state;

    fb_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(FD), .FIFO_DEPTH(4), .WR_VBLANK_ONLY(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vblank_i(vblank),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .fifo_level_o(fifo_level), .addr_err_o(addr_err),
        .gnt_state_o(gnt_state)
    );

    // Second DUT: writes only during vblank
    logic          vb_vblank, vb_rd_req, vb_rd_valid, vb_wr_valid, vb_wr_ready;
    logic [AW-1:0] vb_rd_addr, vb_wr_addr, vb_mem_addr;
    logic [DW-1:0] vb_rd_data, vb_wr_data, vb_mem_wdata, vb_mem_rdata;
    logic          vb_mem_en, vb_mem_we, vb_addr_err;
    logic [2:0]    vb_fifo_level;
    logic [1:0]    vb_gnt_state;

    fb_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(FD), .FIFO_DEPTH(4), .WR_VBLANK_ONLY(1)
    ) dut_vb (
        .clk(clk), .rst_n(rst_n), .vblank_i(vb_vblank),
        .rd_req_i(vb_rd_req), .rd_addr_i(vb_rd_addr), .rd_data_o(vb_rd_data), .rd_valid_o(vb_rd_valid),
        .wr_valid_i(vb_wr_valid), .wr_ready_o(vb_wr_ready), .wr_addr_i(vb_wr_addr), .wr_data_i(vb_wr_data),
        .mem_en_o(vb_mem_en), .mem_we_o(vb_mem_we), .mem_addr_o(vb_mem_addr), .mem_wdata_o(vb_mem_wdata),
        .mem_rdata_i(vb_mem_rdata), .fifo_level_o(vb_fifo_level), .addr_err_o(vb_addr_err),
        .gnt_state_o(vb_gnt_state)
    );

    // BRAM model: address 100 is preloaded with 8'hA5, one-cycle read latency
    logic [DW-1:0] bram [0:1023];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= (mem_addr == AW'(100)) ? 8'hA5 : bram[mem_addr[9:0]];
        end
    end

    // Scoreboard
    int total = 0;
    int bad   = 0;
    logic [DW-1:0]    rd_exp_q [$];
    logic [AW+DW-1:0] wr_exp_q [$];
    logic [AW+DW-1:0] mon_e;
    logic [DW-1:0]    mon_d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Expected read timing: request seen at an edge -> BRAM slot next cycle,
    // rd_valid the cycle after.
    logic          exp_v1, exp_v2, exp_ok1;
    logic [AW-1:0] exp_a1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_v1 <= 1'b0; exp_v2 <= 1'b0; exp_ok1 <= 1'b0; exp_a1 <= '0;
        end else begin
            exp_v1  <= rd_req;
            exp_ok1 <= (rd_addr < AW'(FD));
            exp_a1  <= rd_addr;
            exp_v2  <= exp_v1;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_v1) begin
                chk("rd_slot_en", 32'(mem_en), 32'(exp_ok1));
                chk("rd_slot_we", 32'(mem_we), 32'd0);
                if (exp_ok1) chk("rd_slot_addr", 32'(mem_addr), 32'(exp_a1));
            end
            if (rd_valid || exp_v2) chk("rd_valid_timing", 32'(rd_valid), 32'(exp_v2));
            if (rd_valid) begin
                if (rd_exp_q.size() == 0) fail("rd_unexpected");
                else begin
                    mon_d = rd_exp_q.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(mon_d));
                end
            end
            if (mem_en && mem_we) begin
                if (wr_exp_q.size() == 0) fail("wr_unexpected");
                else begin
                    mon_e = wr_exp_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(mon_e[AW+DW-1:DW]));
                    chk("wr_data", 32'(mem_wdata), 32'(mon_e[DW-1:0]));
                end
            end
        end
    end

    // Driver: one cycle of stimulus, entered and left at posedge+1
    logic [2:0] lvl_s;
    logic       rdy_s;
    logic       acc;

    task automatic step(input logic rd, input logic [AW-1:0] ra, input logic [DW-1:0] re,
                        input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        output logic accepted);
        rd_req = rd; rd_addr = ra;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        if (rd) rd_exp_q.push_back(re);
        @(negedge clk);
        lvl_s = fifo_level;
        rdy_s = wr_ready;
        accepted = wv && wr_ready;
        if (accepted && (wa < AW'(FD))) wr_exp_q.push_back({wa, wd});
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        wr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, '0, '0, a);
    endtask

    task automatic wait_empty(input string nm);
        logic a;
        for (int k = 0; k < 20 && fifo_level != 3'd0; k++) step(1'b0, '0, '0, 1'b0, '0, '0, a);
        chk(nm, 32'(fifo_level), 32'd0);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n;

    initial begin
        vblank = 1'b0; rd_req = 1'b0; rd_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        vb_vblank = 1'b0; vb_rd_req = 1'b0; vb_rd_addr = '0;
        vb_wr_valid = 1'b0; vb_wr_addr = '0; vb_wr_data = '0; vb_mem_rdata = '0;

        // Reset: held low three cycles
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_wr_ready", 32'(wr_ready), 32'd1);
        chk("idle_mem_en", 32'(mem_en), 32'd0);
        chk("idle_level", 32'(fifo_level), 32'd0);
        chk("idle_addr_err", 32'(addr_err), 32'd0);
        chk("idle_gnt", 32'(gnt_state), 32'd0);
        @(posedge clk); #1;

        // Read latency: addr 100 -> 8'hA5
        step(1'b1, AW'(100), 8'hA5, 1'b0, '0, '0, acc);
        idle(3);

        // Write drain while display reads every other cycle
        n = 0;
        for (int i = 0; i < 20 && n < 4; i++) begin
            step((i % 2) == 0, AW'(100), 8'hA5, 1'b1, AW'(n), 8'(8'h10 + n), acc);
            if (acc) n++;
        end
        chk("drain_accepted", 32'(n), 32'd4);
        wait_empty("drain_empty");
        for (int i = 0; i < 4; i++) step(1'b1, AW'(i), 8'(8'h10 + i), 1'b0, '0, '0, acc);
        idle(3);

        // FIFO full under continuous reads
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, AW'(100), 8'hA5, 1'b1, AW'(8 + i), 8'(8'h20 + i), acc);
            if (acc) n++;
        end
        chk("full_accepted4", 32'(n), 32'd4);
        step(1'b1, AW'(100), 8'hA5, 1'b1, AW'(12), 8'h24, acc);
        chk("full_ready", 32'(rdy_s), 32'd0);
        chk("full_level", 32'(lvl_s), 32'd4);
        chk("full_reject", 32'(acc), 32'd0);
        step(1'b0, '0, '0, 1'b1, AW'(12), 8'h24, acc);
        chk("pop_cycle_ready", 32'(rdy_s), 32'd0);
        chk("pop_cycle_reject", 32'(acc), 32'd0);
        step(1'b1, AW'(100), 8'hA5, 1'b1, AW'(12), 8'h24, acc);
        chk("reassert_ready", 32'(rdy_s), 32'd1);
        chk("reassert_level", 32'(lvl_s), 32'd3);
        chk("fifth_accepted", 32'(acc), 32'd1);
        wait_empty("full_drain_empty");
        idle(2);

        // Out-of-range accesses
        chk("err_before", 32'(addr_err), 32'd0);
        step(1'b0, '0, '0, 1'b1, AW'(307200), 8'h55, acc);
        chk("oor_wr_accepted", 32'(acc), 32'd1);
        idle(3);
        chk("oor_wr_level", 32'(fifo_level), 32'd0);
        chk("oor_wr_err", 32'(addr_err), 32'd1);
        step(1'b1, AW'(307201), 8'h00, 1'b0, '0, '0, acc);
        idle(6);
        chk("err_sticky", 32'(addr_err), 32'd1);

        // Reset mid-operation: in-flight read and buffered write are lost
        rd_req = 1'b1; rd_addr = AW'(100);
        wr_valid = 1'b1; wr_addr = AW'(30); wr_data = 8'h77;
        @(posedge clk); #1;
        rd_req = 1'b0; wr_valid = 1'b0;
        chk("pre_rst_en", 32'(mem_en), 32'd1);
        chk("pre_rst_level", 32'(fifo_level), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_en_drop", 32'(mem_en), 32'd0);
        chk("async_level_clr", 32'(fifo_level), 32'd0);
        chk("async_err_clr", 32'(addr_err), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_rd_valid", 32'(rd_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle(4);
        chk("post_rst_ready", 32'(wr_ready), 32'd1);

        // Vblank gating on the second instance
        vb_vblank = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vb_wr_valid = 1'b1; vb_wr_addr = AW'(40 + i); vb_wr_data = 8'(8'h60 + i);
            chk("vb_ready", 32'(vb_wr_ready), 32'd1);
            @(posedge clk); #1;
        end
        vb_wr_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("vb_no_we", 32'(vb_mem_we), 32'd0);
        end
        chk("vb_level_held", 32'(vb_fifo_level), 32'd2);
        @(posedge clk); #1;
        vb_vblank = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("vb_we1", 32'(vb_mem_we), 32'd1);
        chk("vb_addr1", 32'(vb_mem_addr), 32'd40);
        chk("vb_data1", 32'(vb_mem_wdata), 32'h60);
        @(posedge clk); @(negedge clk);
        chk("vb_we2", 32'(vb_mem_we), 32'd1);
        chk("vb_addr2", 32'(vb_mem_addr), 32'd41);
        chk("vb_data2", 32'(vb_mem_wdata), 32'h61);
        chk("vb_level_zero", 32'(vb_fifo_level), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("vb_we_done", 32'(vb_mem_we), 32'd0);
        @(posedge clk); #1;

        chk("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        chk("wr_queue_drained", 32'(wr_exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single-port 8-bit frame-buffer BRAM between two requesters.
  - Display read requester (the VGA pixel fetch path): real-time, strict priority.
  - Write requester (image loader/camera path): valid/ready handshake, buffered in a small write FIFO.
  - Writes drain into BRAM only in cycles the display does not use the port.
- Sits between the VGA pixel pipeline/loader and the frame-buffer BRAM.

Parameters:
- ADDR_W, 19, frame-buffer address width.
- DATA_W, 8, pixel width (RGB332).
- FB_DEPTH, 307200, valid address count (640x480); addresses >= FB_DEPTH are illegal.
- FIFO_DEPTH, 4, write FIFO entries (power of two, >= 2).
- WR_VBLANK_ONLY, 0, 1 = writes commit to BRAM only while vblank=1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- vblank  in  1  high during vertical blanking.
- rd_req  in  1  display read request, single-cycle pulse per pixel.
- rd_addr  in  ADDR_W  display read address, valid with rd_req.
- rd_data  out  DATA_W  read pixel.
- rd_valid  out  1  rd_data valid, one pulse per rd_req.
- wr_valid  in  1  write request.
- wr_ready  out  1  FIFO can accept.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write pixel.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_W  BRAM address.
- mem_wdata  out  DATA_W  BRAM write data.
- mem_rdata  in  DATA_W  BRAM read data, 1-cycle latency after mem_en.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- addr_err  out  1  sticky: an out-of-range write or read was seen.

Behaviour:
- Reset (rst_n=0, async): all outputs 0 except wr_ready=1; FIFO empty; grant state IDLE.
- Grant FSM, evaluated every clk edge. States:
  - IDLE: no BRAM access.
  - RD: read issued.
  - WR: write issued.
- Next-state selection:
  - rd_req=1 -> RD.
  - else FIFO non-empty and (WR_VBLANK_ONLY=0 or vblank=1) -> WR.
  - else IDLE.
  - Strict read priority: a write never delays a read.
- Registered BRAM drive: the cycle after the decision, mem_en/mem_we/mem_addr/mem_wdata reflect the grant.
- RD: mem_en=1, mem_we=0, mem_addr=rd_addr captured at request.
- WR: mem_en=1, mem_we=1, head entry popped at the decision edge.
- IDLE: mem_en=0, mem_we=0; mem_addr/mem_wdata hold their last value.
- Read latency: rd_req at edge N -> mem_en at N+1 -> rd_valid=1 and rd_data=mem_rdata at N+2, one-cycle pulse.
  - Back-to-back rd_req every cycle is supported, fully pipelined.
- Out-of-range read (rd_addr >= FB_DEPTH):
  - mem_en=0 in the RD slot.
  - rd_valid still pulses at N+2 with rd_data=0.
  - addr_err set.
- Write FIFO:
  - push when wr_valid & wr_ready.
  - wr_ready = (level < FIFO_DEPTH), registered from the next-cycle level.
  - Full: wr_ready=0 even if a pop happens that cycle; ready reasserts one cycle after the pop.
  - Empty with push: no pop that cycle; the entry is eligible the next cycle.
  - Simultaneous push and pop at a level between 1 and FIFO_DEPTH-1: level unchanged.
- Out-of-range write: entry is popped in a WR slot with mem_en=0, mem_we=0, and addr_err is set.
- addr_err is cleared only by reset.
- vblank falling while FIFO is non-empty and WR_VBLANK_ONLY=1: remaining entries stall until the next vblank; wr_ready follows the FIFO level.
- Pointers wrap modulo FIFO_DEPTH. fifo_level never exceeds FIFO_DEPTH.
- Reset mid-operation:
  - In-flight read is discarded, no rd_valid.
  - FIFO contents are lost.
  - mem_en drops asynchronously.

Decomposition:
- Shared package fb_pkg:
  - ADDR_W, DATA_W, FB_DEPTH.
  - Grant encoding GNT_IDLE=2'd0, GNT_RD=2'd1, GNT_WR=2'd2.
- Sub-module fb_wr_fifo:
  - Synchronous FIFO of {addr,data}.
  - Signals: push, pop, head outputs, level, full, empty.
  - Same clk/rst_n.
- Grant FSM, BRAM drive registers and read-valid pipeline live in fb_port_arbiter.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> wr_ready=1, mem_en=0, fifo_level=0, addr_err=0.
- Read latency: rd_req at cycle 10, rd_addr=100, BRAM[100]=8'hA5.
  - cycle 11: mem_en=1, mem_we=0, mem_addr=100.
  - cycle 12: rd_valid=1, rd_data=8'hA5.
- Write drain while display is active:
  - rd_req asserted every other cycle; push 4 writes addr 0..3, data 8'h10..8'h13.
  - Writes land only in non-read cycles, in order; read back returns 8'h10..8'h13.
  - No read is delayed.
- FIFO full:
  - rd_req held high continuously; push 5 writes.
  - wr_ready=0 after the 4th; fifo_level=4.
  - Drop rd_req: one entry pops, wr_ready=1 the following cycle, 5th write accepted.
- Vblank gating:
  - WR_VBLANK_ONLY=1, vblank=0; push 2 writes -> mem_we stays 0, fifo_level=2.
  - Raise vblank -> two consecutive write cycles, fifo_level=0.
- Out-of-range accesses:
  - Write to addr 307200 -> popped, mem_we=0, addr_err=1.
  - Read of addr 307201 -> rd_valid pulses with rd_data=0.
  - addr_err stays 1 until reset.
